ctrl_edicion_campos: RTL and testbench
======================================

Name: ctrl_edicion_campos

Overview:
- Edit-mode controller for the multi-field time-setting path (seconds, minutes, hours up/down counters).
- Detects rising edges on user buttons and tracks which field is selected.
- Emits a one-cycle increment or decrement pulse to that field's counter, with auto-repeat while a button is held.
- Returns to run mode on a second edit press or after an inactivity timeout; also drives a blink enable for the display.

Parameters:
N_FIELDS, 3, number of editable fields (index 0 = seconds, 1 = minutes, 2 = hours)
HOLD_CYC, 25000000, cycles from up/down press to first auto-repeat pulse
REPEAT_CYC, 5000000, cycles between auto-repeat pulses (must be >= 2)
TIMEOUT_CYC, 500000000, inactivity cycles in EDIT before forced exit to IDLE
BLINK_CYC, 12500000, half-period of blink in EDIT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
btn_edit  in  1  enter/exit edit, level, already synchronised/debounced
btn_left  in  1  select previous field, level
btn_right  in  1  select next field, level
btn_up  in  1  increment selected field, level
btn_down  in  1  decrement selected field, level
edit_active  out  1  high while in EDIT
field_sel  out  N_FIELDS  one-hot selected field, all zero in IDLE
en_up  out  N_FIELDS  one-cycle increment pulse, bit = field
en_down  out  N_FIELDS  one-cycle decrement pulse, bit = field
blink  out  1  display blink enable for selected field

Behaviour:
- Reset (reset=0, async): state=IDLE, sel index=0, edge registers=0, all counters=0; edit_active=0, field_sel=0, en_up=0, en_down=0, blink=0.
- Edge detect: per button, prev register; tick = btn & ~prev. All outputs registered; pulse/state change visible 1 clk after first edge where button sampled high.
- States: IDLE, EDIT.
- IDLE: all outputs 0; up/down/left/right ignored. btn_edit tick -> EDIT, sel=0, idle_cnt=0, blink=1, blink_cnt=0.
- EDIT, priority per cycle, highest first:
  - btn_edit tick -> IDLE; no pulse that cycle.
  - idle_cnt == TIMEOUT_CYC-1 -> IDLE.
  - Navigation: right tick -> sel=(sel==N_FIELDS-1)?0:sel+1; left tick -> sel=(sel==0)?N_FIELDS-1:sel-1; both same cycle -> no change. A navigation tick suppresses any up/down tick in the same cycle.
  - Up tick alone -> en_up[sel]=1 for exactly 1 cycle. Down tick alone -> en_down[sel]=1. Up and down ticks same cycle -> no pulse.
- Auto-repeat:
  - hold_cnt clears on an up or down tick and counts while that single button stays high.
  - At hold_cnt == HOLD_CYC, issue a pulse; then one further pulse every REPEAT_CYC cycles.
  - Stops on release, on the other of up/down also going high, on a navigation change, or on exit from EDIT. After it stops, no repeat until the held button is released and pressed again.
- en_up and en_down are never both nonzero. At most one bit is set, always the currently selected field. Pulses are always separated by >= 1 low cycle, so a downstream rising-edge detector counts each one.
- idle_cnt: cleared on any button tick or any pulse (including repeats); otherwise +1 per cycle in EDIT; saturates; forced to 0 in IDLE.
- blink: in EDIT, toggles when blink_cnt == BLINK_CYC-1; blink_cnt then restarts. blink forced to 1 and blink_cnt cleared on any field change. blink is 0 in IDLE.
- field_sel = one-hot(sel) in EDIT, 0 in IDLE.
- Counter widths sized to hold their parameter max; no arithmetic wrap other than the sel wrap.
- Reset asserted mid-EDIT or mid-repeat: immediate return to reset values; no pulse on deassertion, even if a button is held. A button still high at deassertion does not create a tick until it is released and pressed again (prev registers load the level on the first clk after deassertion).

Test Plan:
Sim params N_FIELDS=3, HOLD_CYC=8, REPEAT_CYC=4, TIMEOUT_CYC=50, BLINK_CYC=5.
1. Reset, then press btn_edit -> edit_active=1, field_sel=001, blink=1; press btn_edit again -> edit_active=0, field_sel=000.
2. In EDIT: btn_right x3 -> field_sel 010, 100, 001. Then btn_left x1 -> 100. Left and right same cycle -> unchanged.
3. field_sel=010, tap btn_up -> en_up=010 for exactly 1 cycle, en_down=000. Tap btn_down -> en_down=010 for 1 cycle.
4. Hold btn_up 30 cycles on field 0 -> pulses at press+1, +8, +12, +16, +20, +24, +28; none after release. Pressing btn_right mid-hold stops repeats.
5. Enter EDIT with no activity -> edit_active falls at cycle 50. With a tap at cycle 40 -> exit at cycle 90. blink toggles every 5 cycles meanwhile.
6. Assert reset during an auto-repeat with btn_up still high -> all outputs 0 immediately. After deassertion, no en_up pulse until btn_up is released and re-pressed. btn_up and btn_down rising together -> no pulse.

Source files
------------

// File: rtl/ctrl_edicion_campos.sv
// Edit-mode controller for the seconds/minutes/hours setting path: field selection,
// inc/dec pulses with auto-repeat, inactivity timeout and display blink.
module ctrl_edicion_campos #(
    parameter int unsigned N_FIELDS    = 3,
    parameter int unsigned HOLD_CYC    = 25000000,
    parameter int unsigned REPEAT_CYC  = 5000000,
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned BLINK_CYC   = 12500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_edit,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_up,
    input  logic                btn_down,
    output logic                edit_active,
    output logic [N_FIELDS-1:0] field_sel,
    output logic [N_FIELDS-1:0] en_up,
    output logic [N_FIELDS-1:0] en_down,
    output logic                blink
);

    localparam int unsigned SelW    = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int unsigned HoldMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);
    localparam int unsigned IdleW   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BlinkW  = $clog2(BLINK_CYC + 1);

    typedef enum logic {StIdle, StEdit} state_e;

    state_e state_q, state_d;

    logic [4:0]          btn_now, prev_q, tick;
    logic                live_q;
    logic                tick_edit, tick_left, tick_right, tick_up, tick_down;
    logic [SelW-1:0]     sel_q, sel_d;
    logic [IdleW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic                rep_act_q, rep_act_d;
    logic                rep_first_q, rep_first_d;
    logic                rep_up_q, rep_up_d;
    logic [N_FIELDS-1:0] field_sel_q, field_sel_d;
    logic [N_FIELDS-1:0] en_up_q, en_up_d;
    logic [N_FIELDS-1:0] en_down_q, en_down_d;

    logic nav_any, field_change, pulse_up, pulse_dn, held, other;

    assign btn_now = {btn_edit, btn_left, btn_right, btn_up, btn_down};
    // live_q masks ticks on the first clock after reset so held buttons need a re-press
    assign tick       = btn_now & ~prev_q & {5{live_q}};
    assign tick_edit  = tick[4];
    assign tick_left  = tick[3];
    assign tick_right = tick[2];
    assign tick_up    = tick[1];
    assign tick_down  = tick[0];

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        idle_cnt_d   = idle_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;
        hold_cnt_d   = hold_cnt_q;
        rep_act_d    = rep_act_q;
        rep_first_d  = rep_first_q;
        rep_up_d     = rep_up_q;
        nav_any      = tick_left | tick_right;
        field_change = tick_left ^ tick_right;
        pulse_up     = 1'b0;
        pulse_dn     = 1'b0;
        held         = rep_up_q ? btn_up : btn_down;
        other        = rep_up_q ? btn_down : btn_up;

        unique case (state_q)
            StIdle: begin
                sel_d       = '0;
                idle_cnt_d  = '0;
                blink_cnt_d = '0;
                blink_d     = 1'b0;
                hold_cnt_d  = '0;
                rep_act_d   = 1'b0;
                rep_first_d = 1'b0;
                if (tick_edit) begin
                    state_d = StEdit;
                    blink_d = 1'b1;
                end
            end
            StEdit: begin
                if (tick_edit || idle_cnt_q == IdleW'(TIMEOUT_CYC - 1)) begin
                    state_d     = StIdle;
                    sel_d       = '0;
                    idle_cnt_d  = '0;
                    blink_cnt_d = '0;
                    blink_d     = 1'b0;
                    hold_cnt_d  = '0;
                    rep_act_d   = 1'b0;
                end else begin
                    if (tick_right && !tick_left) begin
                        sel_d = (sel_q == SelW'(N_FIELDS - 1)) ? '0 : sel_q + SelW'(1);
                    end else if (tick_left && !tick_right) begin
                        sel_d = (sel_q == '0) ? SelW'(N_FIELDS - 1) : sel_q - SelW'(1);
                    end

                    if (field_change) begin
                        rep_act_d = 1'b0;
                    end else if (!nav_any && tick_up && !tick_down) begin
                        pulse_up    = 1'b1;
                        rep_act_d   = !btn_down;
                        rep_up_d    = 1'b1;
                        rep_first_d = 1'b1;
                        // The tick cycle itself counts as the first held cycle
                        hold_cnt_d  = HoldW'(1);
                    end else if (!nav_any && tick_down && !tick_up) begin
                        pulse_dn    = 1'b1;
                        rep_act_d   = !btn_up;
                        rep_up_d    = 1'b0;
                        rep_first_d = 1'b1;
                        hold_cnt_d  = HoldW'(1);
                    end else if (tick_up && tick_down) begin
                        rep_act_d = 1'b0;
                    end else if (rep_act_q) begin
                        if (!held || other) begin
                            rep_act_d = 1'b0;
                        end else if (hold_cnt_q == (rep_first_q ? HoldW'(HOLD_CYC - 1)
                                                                : HoldW'(REPEAT_CYC - 1))) begin
                            pulse_up    = rep_up_q;
                            pulse_dn    = !rep_up_q;
                            rep_first_d = 1'b0;
                            hold_cnt_d  = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HoldW'(1);
                        end
                    end

                    if ((|tick) || pulse_up || pulse_dn) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + IdleW'(1);
                    end

                    if (field_change) begin
                        blink_d     = 1'b1;
                        blink_cnt_d = '0;
                    end else if (blink_cnt_q == BlinkW'(BLINK_CYC - 1)) begin
                        blink_d     = !blink_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BlinkW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        field_sel_d = (state_d == StEdit) ? (N_FIELDS'(1) << sel_d) : '0;
        en_up_d     = N_FIELDS'(pulse_up) << sel_q;
        en_down_d   = N_FIELDS'(pulse_dn) << sel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            live_q      <= 1'b0;
            sel_q       <= '0;
            idle_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            hold_cnt_q  <= '0;
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_up_q    <= 1'b0;
            field_sel_q <= '0;
            en_up_q     <= '0;
            en_down_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= btn_now;
            live_q      <= 1'b1;
            sel_q       <= sel_d;
            idle_cnt_q  <= idle_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            rep_up_q    <= rep_up_d;
            field_sel_q <= field_sel_d;
            en_up_q     <= en_up_d;
            en_down_q   <= en_down_d;
        end
    end

    assign edit_active = (state_q == StEdit);
    assign field_sel   = field_sel_q;
    assign en_up       = en_up_q;
    assign en_down     = en_down_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_ctrl_edicion_campos.sv
// Bench for ctrl_edicion_campos: directed scenarios plus random button activity,
// every cycle compared against a behavioural model of the edit-mode rules.
module tb_ctrl_edicion_campos;

    localparam int unsigned NF   = 3;
    localparam int unsigned HOLD = 8;
    localparam int unsigned REP  = 4;
    localparam int unsigned TMO  = 50;
    localparam int unsigned BLK  = 5;
    localparam int BE = 4, BL = 3, BR = 2, BU = 1, BD = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    btn = '0;
    logic          edit_active, blink;
    logic [NF-1:0] field_sel, en_up, en_down;

    always #5 clk = ~clk;

    ctrl_edicion_campos #(
        .N_FIELDS   (NF),
        .HOLD_CYC   (HOLD),
        .REPEAT_CYC (REP),
        .TIMEOUT_CYC(TMO),
        .BLINK_CYC  (BLK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_edit   (btn[BE]),
        .btn_left   (btn[BL]),
        .btn_right  (btn[BR]),
        .btn_up     (btn[BU]),
        .btn_down   (btn[BD]),
        .edit_active(edit_active),
        .field_sel  (field_sel),
        .en_up      (en_up),
        .en_down    (en_down),
        .blink      (blink)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit       m_live;
    bit [4:0] m_prev;
    bit       m_edit;
    bit       m_blink;
    int       m_sel, m_idle, m_bcnt, m_rep, m_len, m_pulse;  // m_rep/m_pulse: 0 none, 1 up, 2 down

    task automatic model_reset();
        m_live = 0; m_prev = '0; m_edit = 0; m_blink = 0;
        m_sel = 0; m_idle = 0; m_bcnt = 0; m_rep = 0; m_len = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        bit [4:0] t;
        bit te, tl, tr, tu, td, chg, hd, ot;
        t = m_live ? (btn & ~m_prev) : 5'b0;
        m_prev = btn;
        m_live = 1;
        m_pulse = 0;
        te = t[BE]; tl = t[BL]; tr = t[BR]; tu = t[BU]; td = t[BD];
        if (!m_edit) begin
            m_rep = 0;
            if (te) begin
                m_edit = 1; m_sel = 0; m_idle = 0; m_blink = 1; m_bcnt = 0;
            end
        end else if (te || m_idle == int'(TMO) - 1) begin
            m_edit = 0; m_sel = 0; m_blink = 0; m_rep = 0; m_idle = 0; m_bcnt = 0;
        end else begin
            chg = tr != tl;
            if (tr && !tl) m_sel = (m_sel + 1) % NF;
            if (tl && !tr) m_sel = (m_sel + NF - 1) % NF;
            if (chg) begin
                m_rep = 0;
            end else if (!(tl || tr) && (tu != td)) begin
                m_pulse = tu ? 1 : 2;
                m_rep = (tu ? btn[BD] : btn[BU]) ? 0 : m_pulse;
                m_len = 1;
            end else if (tu && td) begin
                m_rep = 0;
            end else if (m_rep != 0) begin
                hd = (m_rep == 1) ? btn[BU] : btn[BD];
                ot = (m_rep == 1) ? btn[BD] : btn[BU];
                if (!hd || ot) begin
                    m_rep = 0;
                end else begin
                    m_len++;
                    if (m_len >= int'(HOLD) && (m_len - int'(HOLD)) % int'(REP) == 0)
                        m_pulse = m_rep;
                end
            end
            m_idle = ((t != 0) || (m_pulse != 0)) ? 0 : m_idle + 1;
            if (chg) begin
                m_blink = 1; m_bcnt = 0;
            end else if (m_bcnt == int'(BLK) - 1) begin
                m_blink = !m_blink; m_bcnt = 0;
            end else begin
                m_bcnt++;
            end
        end
    endtask

    task automatic compare_all();
        check("edit_active", 32'(edit_active), 32'(m_edit));
        check("field_sel", 32'(field_sel), m_edit ? (32'd1 << m_sel) : 32'd0);
        check("en_up", 32'(en_up), (m_pulse == 1) ? (32'd1 << m_sel) : 32'd0);
        check("en_down", 32'(en_down), (m_pulse == 2) ? (32'd1 << m_sel) : 32'd0);
        check("blink", 32'(blink), 32'(m_blink && m_edit));
        check("up_down_excl", 32'((en_up != 0) && (en_down != 0)), 32'd0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic tap(input int b);
        btn[b] = 1'b1;
        step();
        btn[b] = 1'b0;
    endtask

    task automatic measure_exit(input int tap_at, output int k);
        k = 0;
        do begin
            k++;
            if (k == tap_at) btn[BU] = 1'b1;
            step();
            btn[BU] = 1'b0;
        end while (edit_active && k < 200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, cnt2, k;
        logic [2:0] nav_exp [3];
        nav_exp[0] = 3'b010; nav_exp[1] = 3'b100; nav_exp[2] = 3'b001;

        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        step();

        // 1: enter / leave edit
        tap(BE);
        check("t1_enter_active", 32'(edit_active), 32'd1);
        check("t1_enter_sel", 32'(field_sel), 32'b001);
        check("t1_enter_blink", 32'(blink), 32'd1);
        step();
        tap(BE);
        check("t1_exit_sel", 32'(field_sel), 32'd0);
        step();

        // 2: navigation
        tap(BE); step();
        for (int i = 0; i < 3; i++) begin
            tap(BR);
            check("t2_right", 32'(field_sel), 32'(nav_exp[i]));
            step();
        end
        tap(BL);
        check("t2_left_wrap", 32'(field_sel), 32'b100);
        step();
        btn[BL] = 1'b1; btn[BR] = 1'b1;
        step();
        btn[BL] = 1'b0; btn[BR] = 1'b0;
        check("t2_both_nav", 32'(field_sel), 32'b100);
        step();

        // 3: single taps on field 1
        tap(BR); step(); tap(BR); step();
        tap(BU);
        check("t3_up_pulse", 32'(en_up), 32'b010);
        step();
        check("t3_up_one_cycle", 32'(en_up), 32'd0);
        tap(BD);
        check("t3_down_pulse", 32'(en_down), 32'b010);
        step();

        // 4: auto-repeat on field 0
        tap(BE); step(); tap(BE); step();
        cnt = 0;
        btn[BU] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (en_up != 0) cnt++;
        end
        btn[BU] = 1'b0;
        repeat (6) begin
            step();
            if (en_up != 0) cnt++;
        end
        check("t4_repeat_count", 32'(cnt), 32'd7);
        cnt = 0; cnt2 = 0;
        btn[BU] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            btn[BR] = (i == 10);
            step();
            if (en_up != 0) begin
                if (i < 10) cnt++;
                else cnt2++;
            end
        end
        btn[BU] = 1'b0; btn[BR] = 1'b0;
        check("t4_before_nav", 32'(cnt), 32'd2);
        check("t4_after_nav", 32'(cnt2), 32'd0);
        step();

        // 5: inactivity timeout
        tap(BE); step();
        tap(BE);
        measure_exit(0, k);
        check("t5_timeout", 32'(k), 32'd50);
        step();
        tap(BE);
        measure_exit(40, k);
        check("t5_timeout_tap", 32'(k), 32'd90);
        step();

        // 6: reset mid-repeat, then simultaneous up/down
        tap(BE); step();
        btn[BU] = 1'b1;
        repeat (12) step();
        btn[BE] = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t6_rst_en_up", 32'(en_up), 32'd0);
        @(posedge clk); #1;
        compare_all();
        reset = 1'b1;
        repeat (3) step();
        check("t6_edit_held", 32'(edit_active), 32'd0);
        btn[BE] = 1'b0;
        step();
        tap(BE);
        cnt = 0;
        repeat (10) begin
            step();
            if (en_up != 0) cnt++;
        end
        check("t6_no_pulse_held", 32'(cnt), 32'd0);
        btn[BU] = 1'b0;
        step();
        tap(BU);
        check("t6_repress", 32'(en_up), 32'b001);
        step();
        btn[BU] = 1'b1; btn[BD] = 1'b1;
        cnt = 0;
        repeat (12) begin
            step();
            if (en_up != 0 || en_down != 0) cnt++;
        end
        check("t6_up_down_together", 32'(cnt), 32'd0);
        btn = '0;
        step();

        // Random activity
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
            end
            if ($urandom_range(0, 39) == 0) btn[BE] = ~btn[BE];
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(posedge clk); #1;
                compare_all();
                reset = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
